bf16_to_fixed_stream: RTL and testbench

- Streaming converter from bf16 operands to signed two's-complement fixed-point (OUT_W bits, FRAC_BITS fraction bits).
- Sits on the operand-load path in front of the systolic array.
- Inverse of the accumulator-to-bf16 normaliser on the result path.
- Two-stage elastic pipeline with valid/ready on both sides; sticky saturation and NaN status.

---
 rtl/tpu_fp_pkg.sv | 24 ++
 rtl/bf16_classify.sv | 38 +++
 rtl/bf16_to_fixed_stream.sv | 251 +++++++++++++++++++++++++
 tb/tb_bf16_to_fixed_stream.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_fp_pkg.sv
// tpu_fp_pkg: floating-point definitions shared by the operand-load path.
// Contents: bf16 field widths and bias, the bf16 operand class enum, and
// field-extract helper functions. It has no ports.
package tpu_fp_pkg;

   localparam int BF16_BIAS   = 127;
   localparam int BF16_EXP_W  = 8;
   localparam int BF16_MANT_W = 7;

   typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} bf16_cls_e;

   function automatic logic bf16_sign(input logic [15:0] w);
      return w[15];
   endfunction

   function automatic logic [BF16_EXP_W-1:0] bf16_exp(input logic [15:0] w);
      return w[14:7];
   endfunction

   function automatic logic [BF16_MANT_W-1:0] bf16_mant(input logic [15:0] w);
      return w[6:0];
   endfunction

endpackage

// File: rtl/bf16_classify.sv
// bf16_classify: combinational bf16 decode, reusable by any bf16 consumer.
// Ports:
//   bf16_in  in   16  {sign, exp[7:0], mant[6:0]}
//   cls      out  2   ZERO (subnormals flush here) / NORM / INF / NAN
//   sign     out  1   sign bit
//   sig      out  8   significand {1, mant}
//   sh       out  10  signed left-shift that scales sig to value * 2^FRAC_BITS
module bf16_classify
   import tpu_fp_pkg::*;
#(
   parameter int FRAC_BITS = 4
) (
   input  logic [15:0]       bf16_in,
   output bf16_cls_e         cls,
   output logic              sign,
   output logic [7:0]        sig,
   output logic signed [9:0] sh
);

   logic [BF16_EXP_W-1:0]  e;
   logic [BF16_MANT_W-1:0] m;

   always_comb begin
      e    = bf16_exp(bf16_in);
      m    = bf16_mant(bf16_in);
      sign = bf16_sign(bf16_in);
      sig  = {1'b1, m};
      // value = sig * 2^(e - bias - mant_w); the fixed-point scale adds FRAC_BITS
      sh   = $signed({2'b00, e}) - $signed(10'(BF16_BIAS + BF16_MANT_W - FRAC_BITS));
      if (e == '0)
         cls = CLS_ZERO;
      else if (e == '1)
         cls = (m == '0) ? CLS_INF : CLS_NAN;
      else
         cls = CLS_NORM;
   end

endmodule

// File: rtl/bf16_to_fixed_stream.sv
// bf16_to_fixed_stream: streaming bf16 -> signed fixed-point converter for the
// operand-load path. Stage 1 classifies, stage 2 shifts, rounds to nearest-even
// and saturates. Sticky status counts transferred saturated / NaN results.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_bf16     input stream of bf16 words
//   out_valid/out_ready/out_data  output stream, OUT_W-bit two's complement
//   out_sat                       current result was clamped
//   clr_stat                      synchronous clear of sat_flag/nan_flag/sat_count
//   sat_flag, nan_flag, sat_count sticky status, updated on output transfer
// Build option BF16_CVT_SKID_EN: adds a 2-entry output skid buffer so in_ready
// depends only on registered state.
module bf16_to_fixed_stream
   import tpu_fp_pkg::*;
#(
   parameter int OUT_W     = 8,
   parameter int FRAC_BITS = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_bf16,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sat,
   input  logic             clr_stat,
   output logic             sat_flag,
   output logic             nan_flag,
   output logic [CNT_W-1:0] sat_count
);

   localparam int MW = OUT_W + 9;
   localparam logic [MW-1:0]    LIM  = MW'(1) << (OUT_W - 1);
   localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

   bf16_cls_e         c_cls;
   logic              c_sign;
   logic [7:0]        c_sig;
   logic signed [9:0] c_sh;

   bf16_classify #(.FRAC_BITS(FRAC_BITS)) u_cls (
      .bf16_in (in_bf16),
      .cls     (c_cls),
      .sign    (c_sign),
      .sig     (c_sig),
      .sh      (c_sh)
   );

   logic              s1_v_q, s1_v_d, s1_sign_q, s1_sign_d;
   bf16_cls_e         s1_cls_q, s1_cls_d;
   logic [7:0]        s1_sig_q, s1_sig_d;
   logic signed [9:0] s1_sh_q, s1_sh_d;
   logic              s2_v_q, s2_v_d, s2_sat_q, s2_sat_d, s2_nan_q, s2_nan_d;
   logic [OUT_W-1:0]  s2_data_q, s2_data_d;
   logic              sat_flag_q, sat_flag_d, nan_flag_q, nan_flag_d;
   logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

   logic              s1_en, s2_en, out_nan, xfer, sat_ev, nan_ev;
   logic              big, rup, r_sat, r_nan;
   logic [9:0]        rsh;
   logic [16:0]       x;
   logic [MW-1:0]     mag;
   logic [OUT_W-1:0]  r_data;

   // Stage 2 datapath: magnitude, rounding, then saturation on the rounded value
   always_comb begin
      big = 1'b0;
      rup = 1'b0;
      rsh = '0;
      x   = '0;
      mag = '0;
      if (!s1_sh_q[9]) begin
         // any shift >= OUT_W puts the leading 1 beyond every representable value
         if (s1_sh_q >= $signed(10'(OUT_W)))
            big = 1'b1;
         else
            mag = MW'(s1_sig_q) << s1_sh_q[4:0];
      end else begin
         rsh = 10'(-s1_sh_q);
         // 9 fraction bits hold every bit shifted out for rsh <= 9; beyond that the result is 0
         if (rsh <= 10'd9) begin
            x   = {s1_sig_q, 9'b0} >> rsh[3:0];
            rup = x[8] & ((|x[7:0]) | x[9]);
            mag = MW'(x[16:9]) + MW'(rup);
         end
      end

      r_data = '0;
      r_sat  = 1'b0;
      r_nan  = 1'b0;
      case (s1_cls_q)
         CLS_INF: begin
            r_sat  = 1'b1;
            r_data = s1_sign_q ? MINV : MAXV;
         end
         CLS_NAN: r_nan = 1'b1;
         CLS_NORM: begin
            if (!s1_sign_q && (big || mag >= LIM)) begin
               r_sat  = 1'b1;
               r_data = MAXV;
            end else if (s1_sign_q && (big || mag > LIM)) begin
               r_sat  = 1'b1;
               r_data = MINV;
            end else begin
               r_data = s1_sign_q ? OUT_W'(-mag) : OUT_W'(mag);
            end
         end
         default: ;
      endcase
   end

`ifdef BF16_CVT_SKID_EN
   // Skid entries hold {nan, sat, data}; sk0 is the oldest. While the skid holds
   // anything it owns the output, so s2 can keep moving during a stall.
   logic [1:0]       sk_cnt_q, sk_cnt_d;
   logic [OUT_W+1:0] sk0_q, sk0_d, sk1_q, sk1_d, s2_word, head;
   logic             push, pop;

   always_comb begin
      s2_word   = {s2_nan_q, s2_sat_q, s2_data_q};
      head      = (sk_cnt_q != 2'd0) ? sk0_q : s2_word;
      out_valid = (sk_cnt_q != 2'd0) || s2_v_q;
      {out_nan, out_sat, out_data} = head;
      in_ready  = !s1_v_q || !s2_v_q || (sk_cnt_q != 2'd2);
      s2_en     = !s2_v_q || (sk_cnt_q != 2'd2) || out_ready;
      pop       = (sk_cnt_q != 2'd0) && out_ready;
      push      = s2_v_q && s2_en && !((sk_cnt_q == 2'd0) && out_ready);
      sk0_d     = sk0_q;
      sk1_d     = sk1_q;
      sk_cnt_d  = sk_cnt_q;
      case ({push, pop})
         2'b01: begin
            sk0_d    = sk1_q;
            sk_cnt_d = sk_cnt_q - 2'd1;
         end
         2'b10: begin
            if (sk_cnt_q == 2'd0) sk0_d = s2_word;
            else                  sk1_d = s2_word;
            sk_cnt_d = sk_cnt_q + 2'd1;
         end
         2'b11: begin
            if (sk_cnt_q == 2'd1) begin
               sk0_d = s2_word;
            end else begin
               sk0_d = sk1_q;
               sk1_d = s2_word;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sk_cnt_q <= '0;
         sk0_q    <= '0;
         sk1_q    <= '0;
      end else begin
         sk_cnt_q <= sk_cnt_d;
         sk0_q    <= sk0_d;
         sk1_q    <= sk1_d;
      end
   end
`else
   always_comb begin
      out_valid = s2_v_q;
      out_data  = s2_data_q;
      out_sat   = s2_sat_q;
      out_nan   = s2_nan_q;
      s2_en     = !s2_v_q || out_ready;
      in_ready  = !s1_v_q || !s2_v_q || out_ready;
   end
`endif

   always_comb begin
      s1_en     = !s1_v_q || s2_en;
      s1_v_d    = s1_en ? (in_valid && in_ready) : s1_v_q;
      s1_cls_d  = s1_cls_q;
      s1_sign_d = s1_sign_q;
      s1_sig_d  = s1_sig_q;
      s1_sh_d   = s1_sh_q;
      if (s1_en && in_valid && in_ready) begin
         s1_cls_d  = c_cls;
         s1_sign_d = c_sign;
         s1_sig_d  = c_sig;
         s1_sh_d   = c_sh;
      end

      s2_v_d    = s2_en ? s1_v_q : s2_v_q;
      s2_data_d = s2_data_q;
      s2_sat_d  = s2_sat_q;
      s2_nan_d  = s2_nan_q;
      if (s2_en && s1_v_q) begin
         s2_data_d = r_data;
         s2_sat_d  = r_sat;
         s2_nan_d  = r_nan;
      end

      // a clear coinciding with an event leaves that event recorded
      xfer       = out_valid && out_ready;
      sat_ev     = xfer && out_sat;
      nan_ev     = xfer && out_nan;
      sat_flag_d = (sat_flag_q && !clr_stat) || sat_ev;
      nan_flag_d = (nan_flag_q && !clr_stat) || nan_ev;
      if (clr_stat)
         sat_cnt_d = CNT_W'(sat_ev);
      else if (sat_ev && !(&sat_cnt_q))
         sat_cnt_d = sat_cnt_q + 1'b1;
      else
         sat_cnt_d = sat_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q     <= 1'b0;
         s1_cls_q   <= CLS_ZERO;
         s1_sign_q  <= 1'b0;
         s1_sig_q   <= '0;
         s1_sh_q    <= '0;
         s2_v_q     <= 1'b0;
         s2_data_q  <= '0;
         s2_sat_q   <= 1'b0;
         s2_nan_q   <= 1'b0;
         sat_flag_q <= 1'b0;
         nan_flag_q <= 1'b0;
         sat_cnt_q  <= '0;
      end else begin
         s1_v_q     <= s1_v_d;
         s1_cls_q   <= s1_cls_d;
         s1_sign_q  <= s1_sign_d;
         s1_sig_q   <= s1_sig_d;
         s1_sh_q    <= s1_sh_d;
         s2_v_q     <= s2_v_d;
         s2_data_q  <= s2_data_d;
         s2_sat_q   <= s2_sat_d;
         s2_nan_q   <= s2_nan_d;
         sat_flag_q <= sat_flag_d;
         nan_flag_q <= nan_flag_d;
         sat_cnt_q  <= sat_cnt_d;
      end
   end

   assign sat_flag  = sat_flag_q;
   assign nan_flag  = nan_flag_q;
   assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_bf16_to_fixed_stream.sv
// Testbench for bf16_to_fixed_stream (OUT_W=8, FRAC_BITS=4). Expected results
// come from a real-arithmetic model of the bf16 value and its rounding/clamping,
// plus constants for the directed vectors.
module tb_bf16_to_fixed_stream;

   localparam int OUT_W     = 8;
   localparam int FRAC_BITS = 4;
   localparam int CNT_W     = 16;
`ifdef BF16_CVT_SKID_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 2;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0, in_ready;
   logic [15:0]      in_bf16 = '0;
   logic             out_valid, out_ready = 1'b0, out_sat;
   logic [OUT_W-1:0] out_data;
   logic             clr_stat = 1'b0, sat_flag, nan_flag;
   logic [CNT_W-1:0] sat_count;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   bf16_to_fixed_stream #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bf16(in_bf16),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .clr_stat(clr_stat), .sat_flag(sat_flag), .nan_flag(nan_flag), .sat_count(sat_count)
   );

   // Reference: {nan, sat, data} from the numeric value of the bf16 word.
   function automatic logic [OUT_W+1:0] ref_cvt(input logic [15:0] w);
      int e, m;
      logic neg;
      real x, fl, fr, lim;
      logic [OUT_W-1:0] mx, mn, d;
      e   = int'(w[14:7]);
      m   = int'(w[6:0]);
      neg = w[15];
      lim = 2.0 ** real'(OUT_W - 1);
      mx  = OUT_W'((1 << (OUT_W - 1)) - 1);
      mn  = ~mx;
      if (e == 255) return (m != 0) ? {2'b10, {OUT_W{1'b0}}} : {2'b01, neg ? mn : mx};
      if (e == 0) return '0;
      x  = real'(128 + m) * (2.0 ** real'(e - 134 + FRAC_BITS));
      fl = $floor(x);
      fr = x - fl;
      if (fr > 0.5 || (fr == 0.5 && (fl / 2.0 - $floor(fl / 2.0)) != 0.0)) fl = fl + 1.0;
      if (!neg && fl > lim - 1.0) return {2'b01, mx};
      if (neg && fl > lim) return {2'b01, mn};
      d = OUT_W'(neg ? -$rtoi(fl) : $rtoi(fl));
      return {2'b00, d};
   endfunction

   function automatic logic [15:0] rand_word();
      logic [7:0] e;
      int k;
      k = $urandom_range(0, 19);
      if (k == 0)      e = 8'h00;
      else if (k == 1) e = 8'hFF;
      else             e = 8'($urandom_range(110, 140));
      return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
   endfunction

   // advance to the next drive point, just after the falling edge
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid); else n_pass++;
      n_total++; if (out_data !== '0) $display("FAIL reset out_data got %h want 00", out_data); else n_pass++;
      n_total++; if ({out_sat, sat_flag, nan_flag} !== 3'b000) $display("FAIL reset flags got %b want 000", {out_sat, sat_flag, nan_flag}); else n_pass++;
      n_total++; if (sat_count !== '0) $display("FAIL reset sat_count got %0d want 0", sat_count); else n_pass++;
      tick();
      rst = 1'b0;
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready); else n_pass++;
      tick();
   endtask

   // exact values and rounding, each with 2-cycle latency
   task automatic test_values();
      logic [15:0]      w[7]  = '{16'h3F80, 16'hC020, 16'hC100, 16'h3D00, 16'h3D40, 16'h3DC0, 16'h0001};
      logic [OUT_W-1:0] ed[7] = '{8'h10, 8'hD8, 8'h80, 8'h00, 8'h01, 8'h02, 8'h00};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_bf16 = w[i]; in_valid = 1'b1;
         #1;
         n_total++; if (in_ready !== 1'b1) $display("FAIL val_accept[%0d] in_ready got %b want 1", i, in_ready); else n_pass++;
         tick();
         in_valid = 1'b0;
         #1;
         n_total++; if (out_valid !== 1'b0) $display("FAIL val_lat1[%0d] out_valid got %b want 0", i, out_valid); else n_pass++;
         tick(); #1;
         n_total++;
         if ({out_valid, out_sat, out_data} !== {2'b10, ed[i]})
            $display("FAIL val[%0d] %h got v=%b s=%b d=%h want v=1 s=0 d=%h", i, w[i], out_valid, out_sat, out_data, ed[i]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_specials();
      logic [15:0]      w[3]  = '{16'h42C8, 16'hFF80, 16'h7FC0};
      logic [OUT_W-1:0] ed[3] = '{8'h7F, 8'h80, 8'h00};
      logic             es[3] = '{1'b1, 1'b1, 1'b0};
      int               ec[3] = '{1, 2, 2};
      logic             en[3] = '{1'b0, 1'b0, 1'b1};
      out_ready = 1'b1;
      clr_stat = 1'b1; tick(); clr_stat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_bf16 = (i < 3) ? w[i] : 16'h42C8;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         tick(); #1;
         n_total++;
         if ({out_valid, out_sat, out_data} !== {1'b1, (i < 3) ? es[i] : 1'b1, (i < 3) ? ed[i] : 8'h7F})
            $display("FAIL spec[%0d] got v=%b s=%b d=%h", i, out_valid, out_sat, out_data);
         else n_pass++;
         if (i == 3) clr_stat = 1'b1;
         tick();
         clr_stat = 1'b0;
         #1;
         if (i < 3) begin
            n_total++;
            if ({sat_flag, nan_flag, sat_count} !== {1'b1, en[i], CNT_W'(ec[i])})
               $display("FAIL spec_stat[%0d] got sf=%b nf=%b cnt=%0d want sf=1 nf=%b cnt=%0d", i, sat_flag, nan_flag, sat_count, en[i], ec[i]);
            else n_pass++;
         end else begin
            n_total++;
            if ({sat_flag, nan_flag, sat_count} !== {2'b10, CNT_W'(1)})
               $display("FAIL clr_coincide got sf=%b nf=%b cnt=%0d want sf=1 nf=0 cnt=1", sat_flag, nan_flag, sat_count);
            else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0]      w[12];
      logic [OUT_W+1:0] e[12];
      int acc, got;
      for (int i = 0; i < 12; i++) begin
         w[i] = rand_word();
         e[i] = ref_cvt(w[i]);
      end
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1; in_bf16 = w[acc];
         #1;
         if (out_valid) begin
            n_total++;
            if ({out_sat, out_data} !== e[0][OUT_W:0]) $display("FAIL bp_stable c=%0d got %h want %h", c, {out_sat, out_data}, e[0][OUT_W:0]);
            else n_pass++;
         end
         if (in_ready) acc++;
         tick();
      end
      in_bf16 = w[acc];
      #1;
      n_total++; if (acc !== CAP) $display("FAIL bp_accepted got %0d want %0d", acc, CAP); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else n_pass++;
      in_valid = 1'b0;
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (out_valid) begin
            n_total++;
            if (got >= CAP || {out_sat, out_data} !== e[got][OUT_W:0])
               $display("FAIL bp_drain[%0d] got %h want %h", got, {out_sat, out_data}, e[got % 12][OUT_W:0]);
            else n_pass++;
            got++;
         end
         tick();
      end
      n_total++; if (got !== CAP) $display("FAIL bp_drain_count got %0d want %0d", got, CAP); else n_pass++;
      // full-rate streaming afterwards
      for (int c = 0; c < 12; c++) begin
         in_valid = (c < 8); in_bf16 = w[4 + (c % 8)];
         #1;
         if (c < 8) begin
            n_total++; if (in_ready !== 1'b1) $display("FAIL stream_ready c=%0d got %b want 1", c, in_ready); else n_pass++;
         end
         n_total++;
         if (out_valid !== (c >= 2 && c < 10)) $display("FAIL stream_valid c=%0d got %b want %b", c, out_valid, (c >= 2 && c < 10));
         else n_pass++;
         if (c >= 2 && c < 10) begin
            n_total++;
            if ({out_sat, out_data} !== e[4 + c - 2][OUT_W:0]) $display("FAIL stream_data c=%0d got %h want %h", c, {out_sat, out_data}, e[4 + c - 2][OUT_W:0]);
            else n_pass++;
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_random();
      logic [OUT_W+1:0] q[$];
      logic [OUT_W+1:0] ex;
      logic m_sf, m_nf, ev, nv;
      int   m_cnt;
      clr_stat = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
      tick();
      m_sf = 1'b0; m_nf = 1'b0; m_cnt = 0;
      for (int c = 0; c < 410; c++) begin
         in_valid  = (c < 400) && ($urandom_range(0, 9) < 7);
         in_bf16   = rand_word();
         out_ready = (c >= 400) || ($urandom_range(0, 9) < 7);
         clr_stat  = (c < 400) && ($urandom_range(0, 19) == 0);
         #1;
         n_total++;
         if ({sat_flag, nan_flag, sat_count} !== {m_sf, m_nf, CNT_W'(m_cnt)})
            $display("FAIL rnd_stat c=%0d got sf=%b nf=%b cnt=%0d want sf=%b nf=%b cnt=%0d", c, sat_flag, nan_flag, sat_count, m_sf, m_nf, m_cnt);
         else n_pass++;
         if (in_valid && in_ready) q.push_back(ref_cvt(in_bf16));
         ev = 1'b0; nv = 1'b0;
         if (out_valid && out_ready) begin
            n_total++;
            if (q.size() == 0) begin
               $display("FAIL rnd_extra c=%0d unexpected output %h", c, out_data);
            end else begin
               ex = q.pop_front();
               ev = ex[OUT_W]; nv = ex[OUT_W+1];
               if ({out_sat, out_data} !== ex[OUT_W:0]) $display("FAIL rnd_data c=%0d got %h want %h", c, {out_sat, out_data}, ex[OUT_W:0]);
               else n_pass++;
            end
         end
         if (clr_stat) begin
            m_sf = ev; m_nf = nv; m_cnt = int'(ev);
         end else begin
            m_sf = m_sf | ev; m_nf = m_nf | nv;
            if (ev && m_cnt != (1 << CNT_W) - 1) m_cnt++;
         end
         tick();
      end
      clr_stat = 1'b0;
      n_total++; if (q.size() != 0) $display("FAIL rnd_lost got %0d pending want 0", q.size()); else n_pass++;
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_bf16 = 16'h42C8; tick();
      in_bf16 = 16'h3F80; tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL mrst out_valid got %b want 0", out_valid); else n_pass++;
      n_total++;
      if ({sat_flag, nan_flag, sat_count} !== '0) $display("FAIL mrst status got sf=%b nf=%b cnt=%0d want 0", sat_flag, nan_flag, sat_count);
      else n_pass++;
      tick(); tick();
      rst = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_bf16 = 16'hC020;
      #1;
      n_total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL mrst_post rdy/vld got %b want 10", {in_ready, out_valid}); else n_pass++;
      tick();
      in_valid = 1'b0;
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL mrst_lat1 out_valid got %b want 0", out_valid); else n_pass++;
      tick(); #1;
      n_total++; if ({out_valid, out_data} !== {1'b1, 8'hD8}) $display("FAIL mrst_first got v=%b d=%h want v=1 d=d8", out_valid, out_data); else n_pass++;
      tick(); #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL mrst_ghost out_valid got %b want 0", out_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_values();
      test_specials();
      test_backpressure();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
